// File: rtl/fpu_int_to_fp64_pkg.sv
// Shared FP64 converter definitions: FSM encoding, exponent constants and the
// per-step normalisation shift schedule.
package fpu_int_to_fp64_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_NORM  = 2'd1,
        ST_ROUND = 2'd2,
        ST_DONE  = 2'd3
    } conv_state_t;

    localparam logic [10:0] FP64_BIAS       = 11'd1023;
    // Exponent of a magnitude whose leading one already sits in bit 63.
    localparam logic [10:0] FP64_EXP_OFFSET = 11'd1086;

    // Step k of the normaliser tries a shift of 32 >> k (32,16,8,4,2,1).
    function automatic logic [5:0] norm_amount(input logic [2:0] step);
        return 6'd32 >> step;
    endfunction

endpackage

// File: rtl/fpu_int_to_fp64_rne_round64.sv
// Round-to-nearest-even of a normalised 64-bit magnitude into a binary64
// encoding, including the exponent bump on a fraction carry-out.
module fpu_rne_round64
    import fpu_int_to_fp64_pkg::*;
(
    input  logic [63:0] i_m,
    input  logic [5:0]  i_shift,
    input  logic        i_sign,
    output logic [63:0] o_dst,
    output logic        o_inexact
);

    logic        w_guard;
    logic        w_sticky;
    logic        w_inc;
    logic [52:0] w_frac_sum;
    logic        w_carry;
    logic [10:0] w_exp;
    logic        w_nonzero;

    assign w_guard    = i_m[10];
    assign w_sticky   = |i_m[9:0];
    assign w_inc      = w_guard & (w_sticky | i_m[11]);
    assign w_frac_sum = {1'b0, i_m[62:11]} + {52'd0, w_inc};
    assign w_carry    = w_frac_sum[52];
    assign w_exp      = FP64_EXP_OFFSET - {5'd0, i_shift} + {10'd0, w_carry};

    // After normalisation only a zero operand lacks a leading one in bit 63.
    assign w_nonzero  = i_m[63];

    assign o_dst      = w_nonzero ? {i_sign, w_exp, w_frac_sum[51:0]} : 64'd0;
    assign o_inexact  = w_nonzero & (w_guard | w_sticky);

endmodule

// File: rtl/fpu_int_to_fp64.sv
// Multi-cycle signed int32/int64 to binary64 converter: one request at a time,
// six-step binary normaliser, then a registered rounding stage.
module fpu_int_to_fp64
    import fpu_int_to_fp64_pkg::*;
(
    input  logic        clk,
    input  logic        reset_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        is32,
    input  logic [63:0] src,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [63:0] dst,
    output logic        inexact
);

    conv_state_t r_state;
    conv_state_t w_state_nxt;
    logic [63:0] r_mag;
    logic        r_sign;
    logic [2:0]  r_cnt;
    logic [5:0]  r_shift;
    logic [63:0] r_dst;
    logic        r_inexact;

    logic [63:0] w_ext;
    logic [63:0] w_abs;
    logic [5:0]  w_amt;
    logic        w_top_zero;
    logic [63:0] w_rnd_dst;
    logic        w_rnd_inexact;

    assign w_ext      = is32 ? {{32{src[31]}}, src[31:0]} : src;
    // -2^63 negates to itself, which is the correct unsigned magnitude.
    assign w_abs      = w_ext[63] ? (~w_ext + 64'd1) : w_ext;
    assign w_amt      = norm_amount(r_cnt);
    assign w_top_zero = (r_mag & ~(64'hFFFF_FFFF_FFFF_FFFF >> w_amt)) == 64'd0;

    fpu_rne_round64 u_round (
        .i_m       (r_mag),
        .i_shift   (r_shift),
        .i_sign    (r_sign),
        .o_dst     (w_rnd_dst),
        .o_inexact (w_rnd_inexact)
    );

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:  if (in_valid) w_state_nxt = ST_NORM;
            ST_NORM:  if (r_cnt == 3'd5) w_state_nxt = ST_ROUND;
            ST_ROUND: w_state_nxt = ST_DONE;
            ST_DONE:  if (out_ready) w_state_nxt = ST_IDLE;
            default:  w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state   <= ST_IDLE;
            r_mag     <= 64'd0;
            r_sign    <= 1'b0;
            r_cnt     <= 3'd0;
            r_shift   <= 6'd0;
            r_dst     <= 64'd0;
            r_inexact <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            case (r_state)
                ST_IDLE: begin
                    if (in_valid) begin
                        r_mag   <= w_abs;
                        r_sign  <= w_ext[63];
                        r_cnt   <= 3'd0;
                        r_shift <= 6'd0;
                    end
                end
                ST_NORM: begin
                    if (w_top_zero) begin
                        r_mag   <= r_mag << w_amt;
                        r_shift <= r_shift + w_amt;
                    end
                    r_cnt <= r_cnt + 3'd1;
                end
                ST_ROUND: begin
                    r_dst     <= w_rnd_dst;
                    r_inexact <= w_rnd_inexact;
                end
                default: begin
                end
            endcase
        end
    end

    assign in_ready  = (r_state == ST_IDLE);
    assign out_valid = (r_state == ST_DONE);
    assign dst       = r_dst;
    assign inexact   = r_inexact;

endmodule

// File: tb/tb_fpu_int_to_fp64.sv
// Directed and randomised checks of the int-to-binary64 converter against an
// arithmetic reference model.
module tb_fpu_int_to_fp64;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic        is32 = 1'b0;
    logic [63:0] src = 64'd0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [63:0] dst;
    logic        inexact;

    int errors = 0;
    int checks = 0;
    logic [63:0] exp_q[$];
    logic        exp_ix_q[$];

    always #5 clk = ~clk;

    fpu_int_to_fp64 dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .is32      (is32),
        .src       (src),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .dst       (dst),
        .inexact   (inexact)
    );

    // Value-level conversion: locate the leading one, keep 53 significant
    // bits, round the discarded remainder to nearest, ties to an even result.
    function automatic logic [64:0] ref_convert(input logic i32, input logic [63:0] s);
        logic [63:0] v, mag, q, rem, half;
        logic        neg, up;
        int          p, e, r;
        v   = i32 ? {{32{s[31]}}, s[31:0]} : s;
        neg = v[63];
        mag = neg ? (64'd0 - v) : v;
        if (mag == 64'd0) return 65'd0;
        p = 0;
        for (int i = 0; i < 64; i++) if (mag[i]) p = i;
        e   = 1023 + p;
        rem = 64'd0;
        if (p <= 52) begin
            q = mag << (52 - p);
        end else begin
            r    = p - 52;
            q    = mag >> r;
            rem  = mag - (q << r);
            half = 64'd1 << (r - 1);
            up   = (rem > half) || ((rem == half) && q[0]);
            q    = q + {63'd0, up};
            if (q[53]) begin
                q = q >> 1;
                e = e + 1;
            end
        end
        return {rem != 64'd0, neg, e[10:0], q[51:0]};
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    // Entered at #1 after a rising edge with the DUT idle.
    task automatic convert(input logic i32, input logic [63:0] s, input logic [63:0] e_dst,
                           input logic e_ix, input string tag);
        int lat;
        exp_q.push_back(e_dst);
        exp_ix_q.push_back(e_ix);
        in_valid = 1'b1;
        is32     = i32;
        src      = s;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        src      = {$urandom, $urandom};
        is32     = $urandom_range(0, 1);
        lat      = 0;
        for (int k = 1; k <= 20 && lat == 0; k++) begin
            @(posedge clk);
            #1;
            if (out_valid) lat = k;
        end
        check({tag, " latency"}, 64'(lat), 64'd7);
        check({tag, " dst"}, dst, exp_q.pop_front());
        check({tag, " inexact"}, {63'd0, inexact}, {63'd0, exp_ix_q.pop_front()});
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check({tag, " back to idle"}, {62'd0, in_ready, out_valid}, 64'd2);
    endtask

    task automatic convert_model(input logic i32, input logic [63:0] s, input string tag);
        logic [64:0] m;
        m = ref_convert(i32, s);
        convert(i32, s, m[63:0], m[64], tag);
    endtask

    initial begin
        logic [63:0] base;
        logic        rnd32;
        logic [63:0] held;

        #2;
        check("reset in_ready", {63'd0, in_ready}, 64'd1);
        check("reset out_valid", {63'd0, out_valid}, 64'd0);
        check("reset dst", dst, 64'd0);
        check("reset inexact", {63'd0, inexact}, 64'd0);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        @(posedge clk);
        #1;

        convert(1'b0, 64'd1, 64'h3FF0000000000000, 1'b0, "one");
        convert(1'b0, 64'h8000000000000000, 64'hC3E0000000000000, 1'b0, "min64");
        convert(1'b0, 64'h0020000000000001, 64'h4340000000000000, 1'b1, "tie even");
        convert(1'b0, 64'h0020000000000003, 64'h4340000000000002, 1'b1, "tie up");
        convert(1'b1, 64'h12345678FFFFFFFF, 64'hBFF0000000000000, 1'b0, "i32 m1");
        convert(1'b1, 64'h0000000080000000, 64'hC1E0000000000000, 1'b0, "i32 min");
        convert(1'b0, 64'h7FFFFFFFFFFFFFFF, 64'h43E0000000000000, 1'b1, "max64 carry");
        convert_model(1'b1, 64'hFFFFFFFF7FFFFFFF, "i32 max");

        // Zero result held under back-pressure while new requests are offered.
        in_valid = 1'b1;
        is32     = 1'b0;
        src      = 64'd0;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (7) @(posedge clk);
        #1;
        check("zero valid", {63'd0, out_valid}, 64'd1);
        check("zero dst", dst, 64'd0);
        check("zero inexact", {63'd0, inexact}, 64'd0);
        for (int k = 0; k < 5; k++) begin
            in_valid = 1'b1;
            src      = {$urandom, $urandom} | 64'd1;
            @(posedge clk);
            #1;
            check("stall dst", dst, 64'd0);
            check("stall in_ready", {63'd0, in_ready}, 64'd0);
            check("stall out_valid", {63'd0, out_valid}, 64'd1);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check("stall release idle", {62'd0, in_ready, out_valid}, 64'd2);
        @(posedge clk);
        #1;
        check("no phantom request", {62'd0, in_ready, out_valid}, 64'd2);

        for (int n = 0; n < 40; n++) begin
            base  = {$urandom, $urandom} >> $urandom_range(0, 63);
            if ($urandom_range(0, 1) == 1) base = 64'd0 - base;
            rnd32 = $urandom_range(0, 1);
            convert_model(rnd32, base, "random");
        end

        // Abort mid-normalisation; the previous non-zero result must vanish.
        convert_model(1'b0, 64'd12345, "pre-reset");
        in_valid = 1'b1;
        src      = 64'd5;
        is32     = 1'b0;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        held = dst;
        reset_n = 1'b0;
        #1;
        check("abort held dst nonzero", {63'd0, held != 64'd0}, 64'd1);
        check("abort out_valid", {63'd0, out_valid}, 64'd0);
        check("abort dst", dst, 64'd0);
        check("abort in_ready", {63'd0, in_ready}, 64'd1);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        convert(1'b0, 64'hFFFFFFFFFFFFFFFF, 64'hBFF0000000000000, 1'b0, "after reset");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/fpu_int_to_fp64.md
FPU_INT_TO_FP64 -- requirements
Module: fpu_int_to_fp64

Interface
REQ-001 clk  in  1  sole clock; all state updates on rising edge.
REQ-002 reset_n  in  1  asynchronous, active-low reset.
REQ-003 in_valid  in  1  request present.
REQ-004 in_ready  out  1  block can accept a request.
REQ-005 is32  in  1  1 = source is signed int32 in src[31:0]; 0 = signed int64.
REQ-006 src  in  64  two's-complement integer operand.
REQ-007 out_valid  out  1  dst/inexact valid.
REQ-008 out_ready  in  1  consumer takes result.
REQ-009 dst  out  64  IEEE-754 binary64 result.
REQ-010 inexact  out  1  result was rounded.

Function
REQ-011 Accept SHALL occur on a rising edge with in_valid=1 and in_ready=1; src and is32 are captured then.
- Input is sampled only at that edge.
REQ-012 is32=1 SHALL sign-extend src[31:0] to 64 bits; src[63:32] ignored.
REQ-013 Sign SHALL be bit 63 of the extended value; magnitude is its two's-complement absolute value as 64-bit unsigned.
- -2^63 yields magnitude 0x8000_0000_0000_0000.
REQ-014 FSM states SHALL be IDLE, NORM, ROUND, DONE; in_ready=1 only in IDLE.
REQ-015 IDLE->NORM on accept; NORM SHALL run exactly 6 cycles with a step counter 0..5.
- Step k left-shifts the magnitude by 32,16,8,4,2,1 respectively when that many top bits are all zero.
- Each shift amount is added to a 6-bit shift total.
REQ-016 NORM->ROUND after step 5; ROUND SHALL register dst/inexact and go to DONE.
- out_valid SHALL rise 7 edges after the accept edge.
REQ-017 Rounding SHALL be round-to-nearest-even on the normalized magnitude m:
- fraction = m[62:11], guard = m[10], sticky = OR(m[9:0]).
- Increment when guard & (sticky | m[11]).
- inexact = guard | sticky.
REQ-018 Biased exponent SHALL be 1086 - shift total; a fraction carry-out SHALL zero the fraction and add 1 to the exponent.
- No overflow is possible (max 1087).
REQ-019 Zero input SHALL produce dst=64'h0 (+0.0), inexact=0, with the same latency.
REQ-020 int32 inputs SHALL always convert exactly (inexact=0).
REQ-021 DONE SHALL hold out_valid=1 and dst/inexact stable until an edge with out_ready=1, then go to IDLE.
- Next accept is possible on the following edge.
REQ-022 in_valid outside IDLE and out_ready outside DONE SHALL be ignored.
REQ-023 Outside DONE, out_valid=0; dst/inexact retain their last value.

Reset
REQ-024 reset_n=0 SHALL immediately force state IDLE, in_ready=1, out_valid=0, dst=64'h0, inexact=0, and clear the counter and shift total.
REQ-025 Reset during NORM/ROUND/DONE SHALL abort the operation with no result delivered.
- The first accept after reset_n rises SHALL convert normally.

Structure
REQ-026 The FSM state encoding, bias constant 1023, and the exponent offset 1086 SHALL live in the shared FPU package used by the FP64 converters.
REQ-027 One sub-module, fpu_rne_round64, SHALL implement the REQ-017/018 combinational rounding and exponent adjust; the FSM and registers stay in fpu_int_to_fp64.

Verification
REQ-028 The bench SHALL cover the following directed scenarios:
- is32=0, src=1 -> dst=0x3FF0000000000000, inexact=0, out_valid 7 edges after accept.
- is32=0, src=0x8000000000000000 -> dst=0xC3E0000000000000, inexact=0.
- is32=0, src=0x0020000000000001 -> 0x4340000000000000, inexact=1 (tie to even); src=0x0020000000000003 -> 0x4340000000000002, inexact=1.
- is32=1, src=0x12345678FFFFFFFF -> 0xBFF0000000000000; is32=1, src=0x0000000080000000 -> 0xC1E0000000000000.
- src=0 -> dst=0; out_ready held 0 for 5 cycles -> dst stable, in_ready=0, in_valid ignored; out_ready=1 -> IDLE next edge.
- reset_n pulsed low during NORM -> out_valid=0, dst=0 immediately; subsequent src=-1 (is32=0) -> 0xBFF0000000000000.
